// File: rtl/card_dealer.sv
// card_dealer: draws one card from a 52-card deck on request.
// The free-running count is sampled as the card index, reduced modulo 52,
// and then advanced past any card that has already been dealt.
// Optional build macro CARD_DEALER_REPLACE_EN: deal with replacement
// (infinite shoe, no dealt mask, o_Empty tied low, o_Dealt saturates at 63).
module card_dealer #(
  parameter int WIDTH = 12
) (
  input  logic             clk_50M,
  input  logic             i_Reset_n,
  input  logic [WIDTH-1:0] i_Count,
  input  logic             i_Deal,
  input  logic             i_Shuffle,
  output logic             o_Busy,
  output logic             o_Valid,
  output logic [3:0]       o_Rank,
  output logic [1:0]       o_Suit,
  output logic [3:0]       o_Points,
  output logic             o_IsAce,
  output logic [5:0]       o_Dealt,
  output logic             o_Empty
);

  typedef enum logic [1:0] {IDLE, REDUCE, PROBE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] r_idx;
  logic [5:0]       slot;
  logic             slot_used;
  logic             load_idx, reduce_idx, advance_idx, commit, clear;
  logic [1:0]       card_suit;
  logic [5:0]       suit_base;
  logic [3:0]       card_rank;
  logic [3:0]       card_points;
  logic [5:0]       dealt_next;

  assign slot   = r_idx[5:0];
  assign o_Busy = (state != IDLE);

`ifdef CARD_DEALER_REPLACE_EN
  assign slot_used  = 1'b0;
  assign o_Empty    = 1'b0;
  assign dealt_next = (o_Dealt == 6'd63) ? o_Dealt : o_Dealt + 6'd1;
`else
  logic [51:0] mask;
  assign slot_used  = mask[slot];
  assign o_Empty    = (o_Dealt == 6'd52);
  assign dealt_next = o_Dealt + 6'd1;
`endif

  // State register
  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= next_state;
  end

  // Next-state and datapath control strobes; shuffle always wins
  always_comb begin
    next_state  = state;
    load_idx    = 1'b0;
    reduce_idx  = 1'b0;
    advance_idx = 1'b0;
    commit      = 1'b0;
    clear       = 1'b0;
    case (state)
      IDLE: begin
        if (i_Shuffle) begin
          clear = 1'b1;
        end else if (i_Deal && !o_Empty) begin
          load_idx   = 1'b1;
          next_state = REDUCE;
        end
      end
      REDUCE: begin
        if (i_Shuffle) begin
          clear      = 1'b1;
          next_state = IDLE;
        end else if (r_idx >= WIDTH'(52)) begin
          reduce_idx = 1'b1;
        end else begin
          next_state = PROBE;
        end
      end
      PROBE: begin
        if (i_Shuffle) begin
          clear      = 1'b1;
          next_state = IDLE;
        end else if (slot_used) begin
          advance_idx = 1'b1;
        end else begin
          commit     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Index to suit/rank/points mapping
  always_comb begin
    if (slot >= 6'd39) begin
      card_suit = 2'd3;
      suit_base = 6'd39;
    end else if (slot >= 6'd26) begin
      card_suit = 2'd2;
      suit_base = 6'd26;
    end else if (slot >= 6'd13) begin
      card_suit = 2'd1;
      suit_base = 6'd13;
    end else begin
      card_suit = 2'd0;
      suit_base = 6'd0;
    end
    card_rank   = 4'(slot - suit_base + 6'd1);
    card_points = (card_rank >= 4'd10) ? 4'd10 : card_rank;
  end

  // Index register, dealt count and registered card outputs
  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_idx    <= '0;
      o_Valid  <= 1'b0;
      o_Rank   <= '0;
      o_Suit   <= '0;
      o_Points <= '0;
      o_IsAce  <= 1'b0;
      o_Dealt  <= '0;
    end else begin
      o_Valid <= commit;
      if (load_idx)    r_idx <= i_Count;
      if (reduce_idx)  r_idx <= r_idx - WIDTH'(52);
      if (advance_idx) r_idx <= (slot == 6'd51) ? '0 : r_idx + WIDTH'(1);
      if (clear)       o_Dealt <= '0;
      if (commit) begin
        o_Rank   <= card_rank;
        o_Suit   <= card_suit;
        o_Points <= card_points;
        o_IsAce  <= (card_rank == 4'd1);
        o_Dealt  <= dealt_next;
      end
    end
  end

`ifndef CARD_DEALER_REPLACE_EN
  // Dealt-card mask
  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n)  mask <= '0;
    else if (clear)  mask <= '0;
    else if (commit) mask[slot] <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_card_dealer.sv
// Directed self-checking bench for card_dealer.
module tb_card_dealer;

`ifdef CARD_DEALER_REPLACE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  logic        clk_50M = 1'b0;
  logic        i_Reset_n;
  logic [11:0] i_Count;
  logic        i_Deal;
  logic        i_Shuffle;
  logic        o_Busy, o_Valid, o_IsAce, o_Empty;
  logic [3:0]  o_Rank, o_Points;
  logic [1:0]  o_Suit;
  logic [5:0]  o_Dealt;

  int n_checks = 0;
  int n_fail   = 0;

  card_dealer #(.WIDTH(12)) dut (
    .clk_50M  (clk_50M),
    .i_Reset_n(i_Reset_n),
    .i_Count  (i_Count),
    .i_Deal   (i_Deal),
    .i_Shuffle(i_Shuffle),
    .o_Busy   (o_Busy),
    .o_Valid  (o_Valid),
    .o_Rank   (o_Rank),
    .o_Suit   (o_Suit),
    .o_Points (o_Points),
    .o_IsAce  (o_IsAce),
    .o_Dealt  (o_Dealt),
    .o_Empty  (o_Empty)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Returns at the negedge where
  // o_Valid is seen high (or after the cycle budget runs out).
  task automatic deal(input string tag, input logic [11:0] cnt, input int exp_lat,
                      input int er, input int es, input int ep, input int eace,
                      input int ed, input int poke_at);
    int lat;
    i_Count = cnt;
    i_Deal  = 1'b1;
    @(posedge clk_50M);
    lat = 1;
    @(negedge clk_50M);
    i_Deal = 1'b0;
    while (!o_Valid && lat < 200) begin
      if (lat == poke_at) begin
        i_Deal  = 1'b1;
        i_Count = 12'd7;
      end else begin
        i_Deal = 1'b0;
      end
      @(posedge clk_50M);
      lat++;
      @(negedge clk_50M);
    end
    i_Deal = 1'b0;
    chk({tag, ".valid"},  32'(o_Valid), 32'd1);
    chk({tag, ".lat"},    32'(lat),     32'(exp_lat));
    chk({tag, ".rank"},   32'(o_Rank),  32'(er));
    chk({tag, ".suit"},   32'(o_Suit),  32'(es));
    chk({tag, ".points"}, 32'(o_Points),32'(ep));
    chk({tag, ".ace"},    32'(o_IsAce), 32'(eace));
    chk({tag, ".dealt"},  32'(o_Dealt), 32'(ed));
  endtask

  task automatic shuffle();
    i_Shuffle = 1'b1;
    @(negedge clk_50M);
    i_Shuffle = 1'b0;
  endtask

  initial begin
    int seen_valid;
    i_Reset_n = 1'b0;
    i_Count   = '0;
    i_Deal    = 1'b0;
    i_Shuffle = 1'b0;
    #5;
    chk("rst.valid", 32'(o_Valid), 32'd0);
    chk("rst.busy",  32'(o_Busy),  32'd0);
    chk("rst.rank",  32'(o_Rank),  32'd0);
    chk("rst.dealt", 32'(o_Dealt), 32'd0);
    chk("rst.empty", 32'(o_Empty), 32'd0);
    @(negedge clk_50M);
    @(negedge clk_50M);
    i_Reset_n = 1'b1;
    @(negedge clk_50M);

    // Fresh deck, count 5 -> idx 5
    deal("d5", 12'd5, 3, 6, 0, 6, 0, 1, -1);
    @(negedge clk_50M);
    chk("d5.pulse", 32'(o_Valid), 32'd0);
    chk("d5.idle",  32'(o_Busy),  32'd0);

    // Count 57 reduces to 5; idx 5 used so probe steps to 6
    deal("d57", 12'd57, REPL ? 4 : 5, REPL ? 6 : 7, 0, REPL ? 6 : 7, 0, 2, -1);

    // Reset in the middle of a long reduce
    i_Count = 12'd4095;
    i_Deal  = 1'b1;
    @(negedge clk_50M);
    i_Deal = 1'b0;
    repeat (10) @(negedge clk_50M);
    chk("mid.busy", 32'(o_Busy), 32'd1);
    #3 i_Reset_n = 1'b0;
    #1;
    chk("arst.valid", 32'(o_Valid), 32'd0);
    chk("arst.busy",  32'(o_Busy),  32'd0);
    chk("arst.rank",  32'(o_Rank),  32'd0);
    chk("arst.dealt", 32'(o_Dealt), 32'd0);
    chk("arst.empty", 32'(o_Empty), 32'd0);
    @(negedge clk_50M);
    i_Reset_n = 1'b1;
    @(negedge clk_50M);
    deal("d0", 12'd0, 3, 1, 0, 1, 1, 1, -1);

    // Fresh deck, count 4095 -> idx 39 after 78 subtractions; extra request while busy ignored
    shuffle();
    chk("shuf.dealt", 32'(o_Dealt), 32'd0);
    deal("d4095", 12'd4095, 81, 1, 3, 1, 1, 1, 5);
    repeat (4) @(negedge clk_50M);
    chk("d4095.nobusy", 32'(o_Busy),  32'd0);
    chk("d4095.dealt2", 32'(o_Dealt), 32'd1);

    // Deal the whole deck with count 0: idx k after probing k used cards
    shuffle();
    for (int k = 0; k < 52; k++) begin
      deal($sformatf("deck%0d", k), 12'd0, REPL ? 3 : 3 + k,
           REPL ? 1 : (k % 13) + 1, REPL ? 0 : k / 13,
           REPL ? 1 : (((k % 13) + 1) >= 10 ? 10 : (k % 13) + 1),
           REPL ? 1 : ((k % 13) == 0 ? 1 : 0), k + 1, -1);
    end
    chk("deck.empty", 32'(o_Empty), REPL ? 32'd0 : 32'd1);
    chk("deck.q50",   32'd50, 32'd50 + 32'(o_Busy));

    // 53rd request: dropped on an empty deck
    i_Count = 12'd0;
    i_Deal  = 1'b1;
    @(negedge clk_50M);
    i_Deal = 1'b0;
    chk("d53.busy", 32'(o_Busy), REPL ? 32'd1 : 32'd0);
    seen_valid = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_50M);
      if (o_Valid) seen_valid++;
    end
    chk("d53.valid", 32'(seen_valid), REPL ? 32'd1 : 32'd0);
    chk("d53.dealt", 32'(o_Dealt), REPL ? 32'd53 : 32'd52);
    shuffle();
    chk("reshuf.dealt", 32'(o_Dealt), 32'd0);
    chk("reshuf.empty", 32'(o_Empty), 32'd0);

    // Shuffle during reduce aborts the deal
    deal("pre", 12'd5, 3, 6, 0, 6, 0, 1, -1);
    i_Count = 12'd4095;
    i_Deal  = 1'b1;
    @(negedge clk_50M);
    i_Deal = 1'b0;
    repeat (5) @(negedge clk_50M);
    i_Shuffle = 1'b1;
    @(negedge clk_50M);
    i_Shuffle = 1'b0;
    chk("abort.busy",  32'(o_Busy),  32'd0);
    chk("abort.dealt", 32'(o_Dealt), 32'd0);
    seen_valid = 0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk_50M);
      if (o_Valid) seen_valid++;
    end
    chk("abort.novalid", 32'(seen_valid), 32'd0);
    chk("abort.rank",    32'(o_Rank),     32'd6);

    // Shuffle and deal together in idle: shuffle wins
    i_Count   = 12'd10;
    i_Deal    = 1'b1;
    i_Shuffle = 1'b1;
    @(negedge clk_50M);
    i_Deal    = 1'b0;
    i_Shuffle = 1'b0;
    chk("both.busy",  32'(o_Busy),  32'd0);
    chk("both.dealt", 32'(o_Dealt), 32'd0);

    // Fresh deck again: idx 5 reuse (with replacement, both draws identical)
    deal("r1", 12'd5, 3, 6, 0, 6, 0, 1, -1);
    deal("r2", 12'd5, REPL ? 3 : 4, REPL ? 6 : 7, 0, REPL ? 6 : 7, 0, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
